// File: rtl/bbox_pkg.sv
// bbox_pkg: shared types and constants for the bounding-box scan controller.
//   bbox_ctrl_state_t : controller job FSM states
//   COORD_W / ADDR_W  : coordinate and image-RAM address widths
//   bbox_result_t     : post-processed scan result, also used by the host register block
package bbox_pkg;

    localparam int COORD_W = 11;
    localparam int ADDR_W  = 32;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_ARMED,
        ST_RUN,
        ST_ABORT,
        ST_RESULT
    } bbox_ctrl_state_t;

    typedef struct packed {
        logic [COORD_W-1:0] xmin;
        logic [COORD_W-1:0] xmax;
        logic [COORD_W-1:0] ymin;
        logic [COORD_W-1:0] ymax;
        logic [COORD_W-1:0] w;
        logic [COORD_W-1:0] h;
        logic               empty;
        logic               err;
        logic [7:0]         id;
    } bbox_result_t;

endpackage

// File: rtl/bbox_timeout_ctr.sv
// bbox_timeout_ctr: loadable down-counter with terminal-count flag.
//   clk, rst_n  : clock, synchronous active-low reset
//   load_i      : load load_val_i (takes priority over counting)
//   load_val_i  : reload value
//   en_i        : decrement by one (holds at zero)
//   tc_o        : counter is zero
module bbox_timeout_ctr #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             en_i,
    output logic             tc_o
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/bbox_scan_ctrl.sv
// bbox_scan_ctrl: job controller for the bounding-box scan engine.
//   Host job port   : job_valid/job_ready/job_buf
//   Host result port: res_valid/res_ready, res_* (bounds, size, empty, err, id)
//   Engine port     : eng_rst_n, eng_start, eng_done, eng_addr, eng_xmin..eng_ymax
//   Host read port  : host_rd_req/host_rd_addr/host_rd_gnt
//   RAM read address: mem_addr (engine when a job is in flight, host otherwise)
//   busy            : a job is in flight
module bbox_scan_ctrl
    import bbox_pkg::*;
#(
    parameter int WIDTH       = 100,
    parameter int HEIGHT      = 100,
    parameter int FRAME_WORDS = WIDTH * HEIGHT * 3,
    parameter int TIMEOUT     = WIDTH * HEIGHT * 4 + 64
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic               job_buf,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [COORD_W-1:0] res_xmin,
    output logic [COORD_W-1:0] res_xmax,
    output logic [COORD_W-1:0] res_ymin,
    output logic [COORD_W-1:0] res_ymax,
    output logic [COORD_W-1:0] res_w,
    output logic [COORD_W-1:0] res_h,
    output logic               res_empty,
    output logic               res_err,
    output logic [7:0]         res_id,
    output logic               busy,
    output logic               eng_rst_n,
    output logic               eng_start,
    input  logic               eng_done,
    input  logic [ADDR_W-1:0]  eng_addr,
    input  logic [COORD_W-1:0] eng_xmin,
    input  logic [COORD_W-1:0] eng_xmax,
    input  logic [COORD_W-1:0] eng_ymin,
    input  logic [COORD_W-1:0] eng_ymax,
    input  logic               host_rd_req,
    input  logic [ADDR_W-1:0]  host_rd_addr,
    output logic               host_rd_gnt,
    output logic [ADDR_W-1:0]  mem_addr
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    bbox_ctrl_state_t state_q;
    bbox_result_t     res_q;
    bbox_result_t     res_d;
    logic             buf_q;
    logic             abort_cnt_q;
    logic             job_ready_q;
    logic             res_valid_q;
    logic             busy_q;
    logic             eng_start_q;
    logic             accept;
    logic             tmo_tc;
    logic             eng_owns;
    logic [ADDR_W-1:0] base;

    assign accept   = (state_q == ST_IDLE) && job_valid;
    assign eng_owns = (state_q == ST_START) || (state_q == ST_ARMED) || (state_q == ST_RUN);

    // Loaded with TIMEOUT-1 on acceptance; reaches zero in the cycle where an
    // up-count from zero would read TIMEOUT-1.
    bbox_timeout_ctr #(
        .CNT_W (CNT_W)
    ) u_tmo (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (accept),
        .load_val_i (CNT_W'(TIMEOUT - 1)),
        .en_i       (eng_owns),
        .tc_o       (tmo_tc)
    );

    // Successful-scan result built from the live engine bounds.
    always_comb begin
        res_d       = res_q;
        res_d.xmin  = eng_xmin;
        res_d.xmax  = eng_xmax;
        res_d.ymin  = eng_ymin;
        res_d.ymax  = eng_ymax;
        res_d.empty = (eng_xmin > eng_xmax) || (eng_ymin > eng_ymax);
        res_d.w     = res_d.empty ? '0 : (eng_xmax - eng_xmin + COORD_W'(1));
        res_d.h     = res_d.empty ? '0 : (eng_ymax - eng_ymin + COORD_W'(1));
        res_d.err   = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            res_q       <= '0;
            buf_q       <= 1'b0;
            abort_cnt_q <= 1'b0;
            job_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            eng_start_q <= 1'b0;
        end else begin
            eng_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        buf_q       <= job_buf;
                        state_q     <= ST_START;
                        eng_start_q <= 1'b1;
                        job_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                    end
                end
                ST_START: begin
                    state_q <= ST_ARMED;
                end
                ST_ARMED: begin
                    // Engine may still show done from the previous job.
                    if (tmo_tc) begin
                        state_q     <= ST_ABORT;
                        abort_cnt_q <= 1'b0;
                    end else if (!eng_done) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (eng_done) begin
                        res_q       <= res_d;
                        state_q     <= ST_RESULT;
                        res_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else if (tmo_tc) begin
                        state_q     <= ST_ABORT;
                        abort_cnt_q <= 1'b0;
                    end
                end
                ST_ABORT: begin
                    if (abort_cnt_q) begin
                        res_q.xmin  <= '0;
                        res_q.xmax  <= '0;
                        res_q.ymin  <= '0;
                        res_q.ymax  <= '0;
                        res_q.w     <= '0;
                        res_q.h     <= '0;
                        res_q.empty <= 1'b1;
                        res_q.err   <= 1'b1;
                        state_q     <= ST_RESULT;
                        res_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end else begin
                        abort_cnt_q <= 1'b1;
                    end
                end
                ST_RESULT: begin
                    if (res_ready) begin
                        res_q.id    <= res_q.id + 8'd1;
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        job_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    job_ready_q <= 1'b1;
                    res_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    // RAM read-port mux; forced idle while the controller is in reset.
    assign base = buf_q ? ADDR_W'(FRAME_WORDS) : '0;

    always_comb begin
        mem_addr    = '0;
        host_rd_gnt = 1'b0;
        if (rst_n) begin
            if (eng_owns) begin
                mem_addr = base + eng_addr;
            end else begin
                mem_addr    = host_rd_addr;
                host_rd_gnt = host_rd_req;
            end
        end
    end

    assign eng_rst_n = rst_n && (state_q != ST_ABORT);

    assign job_ready = job_ready_q;
    assign res_valid = res_valid_q;
    assign busy      = busy_q;
    assign eng_start = eng_start_q;
    assign res_xmin  = res_q.xmin;
    assign res_xmax  = res_q.xmax;
    assign res_ymin  = res_q.ymin;
    assign res_ymax  = res_q.ymax;
    assign res_w     = res_q.w;
    assign res_h     = res_q.h;
    assign res_empty = res_q.empty;
    assign res_err   = res_q.err;
    assign res_id    = res_q.id;

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// tb_bbox_scan_ctrl: directed bench for bbox_scan_ctrl with a scripted engine model.
module tb_bbox_scan_ctrl;

    localparam int W  = 8;
    localparam int H  = 8;
    localparam int FW = W * H * 3;
    localparam int TO = 50;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        job_valid, job_ready, job_buf;
    logic        res_valid, res_ready;
    logic [10:0] res_xmin, res_xmax, res_ymin, res_ymax, res_w, res_h;
    logic        res_empty, res_err;
    logic [7:0]  res_id;
    logic        busy, eng_rst_n, eng_start;
    logic        host_rd_req, host_rd_gnt;
    logic [31:0] host_rd_addr, mem_addr;
    logic [10:0] eng_xmin, eng_xmax, eng_ymin, eng_ymax;

    // engine model state
    logic        eng_done_q;
    logic [31:0] eng_addr_q;
    logic        run_q, clr_q;
    int          cnt_q;
    logic        eng_hang;
    int          eng_lat;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bbox_scan_ctrl #(
        .WIDTH       (W),
        .HEIGHT      (H),
        .FRAME_WORDS (FW),
        .TIMEOUT     (TO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .job_valid    (job_valid),
        .job_ready    (job_ready),
        .job_buf      (job_buf),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_xmin     (res_xmin),
        .res_xmax     (res_xmax),
        .res_ymin     (res_ymin),
        .res_ymax     (res_ymax),
        .res_w        (res_w),
        .res_h        (res_h),
        .res_empty    (res_empty),
        .res_err      (res_err),
        .res_id       (res_id),
        .busy         (busy),
        .eng_rst_n    (eng_rst_n),
        .eng_start    (eng_start),
        .eng_done     (eng_done_q),
        .eng_addr     (eng_addr_q),
        .eng_xmin     (eng_xmin),
        .eng_xmax     (eng_xmax),
        .eng_ymin     (eng_ymin),
        .eng_ymax     (eng_ymax),
        .host_rd_req  (host_rd_req),
        .host_rd_addr (host_rd_addr),
        .host_rd_gnt  (host_rd_gnt),
        .mem_addr     (mem_addr)
    );

    // Engine: keeps done high until one cycle after sampling start, then scans
    // eng_lat+1 cycles (or forever when hung) and raises done.
    always @(posedge clk) begin
        if (!eng_rst_n) begin
            eng_done_q <= 1'b0;
            run_q      <= 1'b0;
            clr_q      <= 1'b0;
            eng_addr_q <= '0;
            cnt_q      <= 0;
        end else if (eng_start) begin
            clr_q <= 1'b1;
        end else if (clr_q) begin
            clr_q      <= 1'b0;
            eng_done_q <= 1'b0;
            run_q      <= 1'b1;
            cnt_q      <= 0;
            eng_addr_q <= '0;
        end else if (run_q) begin
            eng_addr_q <= (eng_addr_q == FW - 1) ? '0 : eng_addr_q + 1;
            cnt_q      <= cnt_q + 1;
            if (!eng_hang && cnt_q == eng_lat) begin
                eng_done_q <= 1'b1;
                run_q      <= 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_bounds(input int x0, input int x1, input int y0, input int y1);
        eng_xmin = 11'(x0);
        eng_xmax = 11'(x1);
        eng_ymin = 11'(y0);
        eng_ymax = 11'(y1);
    endtask

    // Called at a negedge in IDLE; returns at the negedge of the START cycle.
    task automatic start_job(input logic b);
        job_buf   = b;
        job_valid = 1'b1;
        check("accept_ready", {31'd0, job_ready}, 32'd1);
        check("accept_host_gnt", {31'd0, host_rd_gnt}, {31'd0, host_rd_req});
        tick();
        job_valid = 1'b0;
        check("start_pulse", {31'd0, eng_start}, 32'd1);
        check("start_busy", {31'd0, busy}, 32'd1);
        check("start_ready", {31'd0, job_ready}, 32'd0);
    endtask

    // Runs from START until the result appears; checks the engine owns the RAM port.
    task automatic run_to_done(input logic [31:0] base);
        int t   = 0;
        int bad = 0;
        while (eng_done_q !== 1'b0 && t < 100) begin
            if (host_rd_gnt !== 1'b0 || mem_addr !== base + eng_addr_q ||
                mem_addr < base || mem_addr > base + FW - 1) bad++;
            tick();
            t++;
        end
        while (eng_done_q !== 1'b1 && t < 100) begin
            if (host_rd_gnt !== 1'b0 || mem_addr !== base + eng_addr_q ||
                mem_addr < base || mem_addr > base + FW - 1) bad++;
            if (res_valid !== 1'b0) bad++;
            tick();
            t++;
        end
        check("done_within_budget", {31'd0, (t < 100)}, 32'd1);
        check("engine_owns_port", bad, 0);
        check("valid_before_done_seen", {31'd0, res_valid}, 32'd0);
        tick();
        check("valid_after_done", {31'd0, res_valid}, 32'd1);
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_res(input int x0, input int x1, input int y0, input int y1,
                             input int w, input int h, input int empty, input int err, input int id);
        check("res_xmin", {21'd0, res_xmin}, x0);
        check("res_xmax", {21'd0, res_xmax}, x1);
        check("res_ymin", {21'd0, res_ymin}, y0);
        check("res_ymax", {21'd0, res_ymax}, y1);
        check("res_w", {21'd0, res_w}, w);
        check("res_h", {21'd0, res_h}, h);
        check("res_empty", {31'd0, res_empty}, empty);
        check("res_err", {31'd0, res_err}, err);
        check("res_id", {24'd0, res_id}, id);
        $display("result id=%0d x=%0d..%0d y=%0d..%0d w=%0d h=%0d empty=%0d err=%0d",
                 res_id, res_xmin, res_xmax, res_ymin, res_ymax, res_w, res_h, res_empty, res_err);
    endtask

    task automatic consume();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("consumed_valid", {31'd0, res_valid}, 32'd0);
        check("consumed_ready", {31'd0, job_ready}, 32'd1);
        check("idle_host_gnt", {31'd0, host_rd_gnt}, 32'd1);
        check("idle_mem_addr", mem_addr, host_rd_addr);
    endtask

    initial begin
        int first_valid, first_rst, rst_low, stall_bad;
        rst_n        = 1'b0;
        job_valid    = 1'b0;
        job_buf      = 1'b0;
        res_ready    = 1'b0;
        host_rd_req  = 1'b1;
        host_rd_addr = 32'h0000_1234;
        eng_hang     = 1'b0;
        eng_lat      = 20;
        set_bounds(0, 0, 0, 0);

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_job_ready", {31'd0, job_ready}, 32'd1);
        check("rst_res_valid", {31'd0, res_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_eng_start", {31'd0, eng_start}, 32'd0);
        check("rst_host_gnt", {31'd0, host_rd_gnt}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_eng_rst_n", {31'd0, eng_rst_n}, 32'd0);
        check_res(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_eng_rst_n", {31'd0, eng_rst_n}, 32'd1);
        check("post_rst_host_gnt", {31'd0, host_rd_gnt}, 32'd1);
        check("post_rst_mem_addr", mem_addr, 32'h0000_1234);
        tick();

        // job 0: buffer 1, single pixel at (3,5)
        set_bounds(3, 3, 5, 5);
        start_job(1'b1);
        run_to_done(FW);
        check_res(3, 3, 5, 5, 1, 1, 0, 0, 0);
        consume();

        // job 1: all background
        host_rd_addr = 32'h0000_0777;
        set_bounds(7, 0, 7, 0);
        start_job(1'b0);
        run_to_done(0);
        check_res(7, 0, 7, 0, 0, 0, 1, 0, 1);
        consume();

        // job 2: engine never finishes
        eng_hang    = 1'b1;
        first_valid = 0;
        first_rst   = 0;
        rst_low     = 0;
        job_buf     = 1'b0;
        job_valid   = 1'b1;
        tick();
        job_valid = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k == 1) check("to_start", {31'd0, eng_start}, 32'd1);
            if (k == 10) check("to_mem_addr_buf0", mem_addr, eng_addr_q);
            if (!eng_rst_n) begin
                rst_low++;
                if (first_rst == 0) first_rst = k;
            end
            if (res_valid && first_valid == 0) first_valid = k;
            tick();
        end
        check("to_rst_cycles", rst_low, 2);
        check("to_rst_first", first_rst, 51);
        check("to_valid_cycle", first_valid, 53);
        check_res(0, 0, 0, 0, 0, 0, 1, 1, 2);
        eng_hang = 1'b0;
        consume();

        // job 3: normal after timeout
        set_bounds(1, 6, 2, 4);
        start_job(1'b1);
        run_to_done(FW);
        check_res(1, 6, 2, 4, 6, 3, 0, 0, 3);
        consume();

        // jobs 4/5: back-to-back with result stalled
        set_bounds(0, 7, 0, 7);
        start_job(1'b0);
        run_to_done(0);
        check_res(0, 7, 0, 7, 8, 8, 0, 0, 4);
        job_valid = 1'b1;
        job_buf   = 1'b1;
        set_bounds(2, 2, 0, 7);
        stall_bad = 0;
        repeat (20) begin
            if (job_ready !== 1'b0 || res_valid !== 1'b1 || eng_start !== 1'b0 || busy !== 1'b0)
                stall_bad++;
            tick();
        end
        check("stall_hold", stall_bad, 0);
        check_res(0, 7, 0, 7, 8, 8, 0, 0, 4);
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("b2b_idle_ready", {31'd0, job_ready}, 32'd1);
        check("b2b_no_start_yet", {31'd0, eng_start}, 32'd0);
        check("b2b_valid_dropped", {31'd0, res_valid}, 32'd0);
        tick();
        job_valid = 1'b0;
        check("b2b_start", {31'd0, eng_start}, 32'd1);
        run_to_done(FW);
        check_res(2, 2, 0, 7, 1, 8, 0, 0, 5);
        consume();

        // reset in the middle of a scan
        set_bounds(4, 5, 1, 1);
        start_job(1'b1);
        repeat (8) tick();
        check("midrun_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_eng_rst_n", {31'd0, eng_rst_n}, 32'd0);
        check("midrst_host_gnt", {31'd0, host_rd_gnt}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_ready", {31'd0, job_ready}, 32'd1);
        check("midrst_id", {24'd0, res_id}, 32'd0);
        rst_n = 1'b1;
        tick();
        start_job(1'b1);
        run_to_done(FW);
        check_res(4, 5, 1, 1, 2, 1, 0, 0, 0);
        consume();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the directed sequence stalls.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
